dd_debounce: RTL and testbench
==============================

DD_DEBOUNCE -- requirements
Module: dd_debounce

Interface
REQ-001 Parameter WIDTH, default 1: number of independent bits debounced.
REQ-002 Parameter CNTR_W, default 8: width of each per-bit settle counter.
REQ-003 Parameter DEBOUNCE_CNT, default 100: consecutive stable samples needed to accept a new level; legal range 1 to 2^CNTR_W-1.
REQ-004 Parameter RST_VAL, default 0: value of data_o at reset, with bit i applying to bit i.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 data_sync_i  input  WIDTH  level input, already synchronized to clk; the block does no metastability filtering.
REQ-008 data_o  output  WIDTH  debounced level, registered.
REQ-009 rise_o  output  WIDTH  one-cycle pulse per bit when that bit of data_o goes 0->1, registered.
REQ-010 fall_o  output  WIDTH  one-cycle pulse per bit when that bit of data_o goes 1->0, registered.
REQ-011 busy_o  output  WIDTH  per bit: 1 while that bit is in SETTLING, registered.

Function
REQ-012 Each bit i has its own FSM, counter cnt[i] (CNTR_W bits) and accepted level data_o[i], with no interaction between bits.
REQ-013 FSM states: STABLE and SETTLING.
REQ-014 STABLE, sample equals data_o[i]: stay in STABLE; cnt holds at 0.
REQ-015 STABLE, sample differs, DEBOUNCE_CNT>1: go to SETTLING; cnt=1.
REQ-016 STABLE, sample differs, DEBOUNCE_CNT==1: data_o[i] takes the sample on that same edge; stay in STABLE.
REQ-017 SETTLING, sample equals data_o[i] (glitch): go to STABLE; cnt=0; data_o unchanged; no pulse.
REQ-018 SETTLING, sample differs and cnt==DEBOUNCE_CNT-1: data_o[i] inverts; go to STABLE; cnt=0.
REQ-019 SETTLING, sample differs and cnt<DEBOUNCE_CNT-1: cnt increments; stay in SETTLING.
REQ-020 Net effect: data_o[i] updates on the clock edge that samples the DEBOUNCE_CNT-th consecutive differing value of data_sync_i[i].
REQ-021 Any reversion to the old level restarts the count from zero; there is no partial credit.
REQ-022 cnt never exceeds DEBOUNCE_CNT-1; no wrap-around.
REQ-023 rise_o[i]/fall_o[i] assert on the same edge that data_o[i] updates and deassert on the next edge; the two are never 1 simultaneously.
REQ-024 busy_o[i]=1 exactly when bit i's FSM is in SETTLING.

Reset
REQ-025 While rst_n=0, asynchronously: data_o=RST_VAL, rise_o=0, fall_o=0, busy_o=0, all cnt=0, all FSMs=STABLE.
REQ-026 Reset asserted mid-SETTLING discards the partial count; no pulse is generated by reset or by reset release.
REQ-027 After release, the first posedge evaluates data_sync_i against RST_VAL per REQ-014 to REQ-016.

Configuration
REQ-028 Macro DD_DEBOUNCE_EDGE_EN defined: rise_o/fall_o behave per REQ-023.
REQ-029 Macro DD_DEBOUNCE_EDGE_EN undefined: rise_o/fall_o remain ports but are tied to constant 0 and no edge registers are generated; all other behaviour is identical.

Verification
REQ-030 Reset: WIDTH=2, RST_VAL=2'b10, data_sync_i=2'b01 during reset -> data_o=2'b10, rise_o=fall_o=busy_o=0; after release, data_o becomes 2'b01 only after 100 stable samples.
REQ-031 Clean step: DEBOUNCE_CNT=4, data_sync_i 0->1 held -> busy_o=1 for 3 cycles; data_o=1 on the 4th sampling edge; rise_o=1 for exactly 1 cycle.
REQ-032 Glitch: DEBOUNCE_CNT=4, input high for 3 cycles then low -> data_o stays 0, rise_o never asserts, busy_o returns to 0.
REQ-033 Restart: DEBOUNCE_CNT=4, pattern 1,1,1,0,1,1,1,1 -> data_o rises on the 8th edge, not earlier.
REQ-034 Independence and falling edge: WIDTH=2, bit0 falls and bit1 glitches in the same cycles -> only fall_o[0] pulses; bit1 is unchanged.
REQ-035 Reset mid-settle and macro-off: rst_n pulse at cnt=2 -> no pulse, count restarts; DEBOUNCE_CNT=1 with macro undefined -> data_o follows input with 1-cycle latency and rise_o/fall_o stay 0.

Source files
------------

// File: rtl/dd_debounce.sv
// dd_debounce: independent per-bit counter debouncer with registered level, busy and edge outputs.
// Define DD_DEBOUNCE_EDGE_EN to generate the rise_o/fall_o pulse registers; otherwise they are tied low.
module dd_debounce #(
  parameter int               WIDTH        = 1,
  parameter int               CNTR_W       = 8,
  parameter int               DEBOUNCE_CNT = 100,
  parameter logic [WIDTH-1:0] RST_VAL      = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_sync_i,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] busy_o
);

  typedef enum logic {
    STABLE,
    SETTLING
  } state_t;

  // Count value on which the DEBOUNCE_CNT-th consecutive differing sample is seen.
  localparam logic [CNTR_W-1:0] LAST = CNTR_W'(DEBOUNCE_CNT - 1);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    state_t            state_q, state_d;
    logic [CNTR_W-1:0] cnt_q, cnt_d;
    logic              data_q, data_d;
    logic              sample;

    assign sample = data_sync_i[i];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= STABLE;
        cnt_q   <= '0;
        data_q  <= RST_VAL[i];
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        data_q  <= data_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      case (state_q)
        STABLE: begin
          cnt_d = '0;
          if (sample != data_q) begin
            if (DEBOUNCE_CNT == 1) begin
              data_d = sample;
            end else begin
              state_d = SETTLING;
              cnt_d   = CNTR_W'(1);
            end
          end
        end
        SETTLING: begin
          // Any sample matching the accepted level throws away the partial count.
          if (sample == data_q) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q == LAST) begin
            state_d = STABLE;
            cnt_d   = '0;
            data_d  = ~data_q;
          end else begin
            cnt_d = cnt_q + CNTR_W'(1);
          end
        end
        default: begin
          state_d = STABLE;
          cnt_d   = '0;
        end
      endcase
    end

    assign data_o[i] = data_q;
    assign busy_o[i] = (state_q == SETTLING);

`ifdef DD_DEBOUNCE_EDGE_EN
    logic rise_q, fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= data_d & ~data_q;
        fall_q <= ~data_d & data_q;
      end
    end

    assign rise_o[i] = rise_q;
    assign fall_o[i] = fall_q;
`else
    assign rise_o[i] = 1'b0;
    assign fall_o[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_dd_debounce.sv
// Self-checking bench for dd_debounce: table-driven vectors through a scoreboard queue,
// plus hand-written reset sequences. Edge expectations follow DD_DEBOUNCE_EDGE_EN.
module tb_dd_debounce;

  typedef struct {
    logic [1:0] din;
    logic [1:0] data;
    logic [1:0] busy;
    logic [1:0] rise;
    logic [1:0] fall;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic [1:0] din_def = 2'b01;
  logic [1:0] data_def, rise_def, fall_def, busy_def;
  logic [1:0] din_four = 2'b01;
  logic [1:0] data_four, rise_four, fall_four, busy_four;
  logic       din_one = 1'b0;
  logic       data_one, rise_one, fall_one, busy_one;

  int   checks = 0;
  int   fails = 0;
  int   sel = 0;
  int   vec_idx = 0;
  string phase = "init";
  vec_t sb[$];
  vec_t tab[$];

  always #5 clk = ~clk;

  // Default debounce length with a mixed reset value.
  dd_debounce #(.WIDTH(2), .RST_VAL(2'b10)) u_def (
    .clk(clk), .rst_n(rst_n), .data_sync_i(din_def),
    .data_o(data_def), .rise_o(rise_def), .fall_o(fall_def), .busy_o(busy_def));

  // Short debounce for the multi-cycle corner cases.
  dd_debounce #(.WIDTH(2), .CNTR_W(4), .DEBOUNCE_CNT(4), .RST_VAL(2'b01)) u_four (
    .clk(clk), .rst_n(rst_n), .data_sync_i(din_four),
    .data_o(data_four), .rise_o(rise_four), .fall_o(fall_four), .busy_o(busy_four));

  dd_debounce #(.WIDTH(1), .DEBOUNCE_CNT(1)) u_one (
    .clk(clk), .rst_n(rst_n), .data_sync_i(din_one),
    .data_o(data_one), .rise_o(rise_one), .fall_o(fall_one), .busy_o(busy_one));

  // Edge expectations are written as if pulses exist; they collapse to 0 when the feature is off.
  function automatic vec_t mk(logic [1:0] din, logic [1:0] data, logic [1:0] busy,
                              logic [1:0] rise, logic [1:0] fall);
    vec_t v;
    v.din  = din;
    v.data = data;
    v.busy = busy;
`ifdef DD_DEBOUNCE_EDGE_EN
    v.rise = rise;
    v.fall = fall;
`else
    v.rise = 2'b00;
    v.fall = 2'b00;
`endif
    return v;
  endfunction

  function automatic void check(string name, logic [1:0] act, logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endfunction

  task automatic applyStimulus(input vec_t v);
    case (sel)
      0:       din_def  = v.din;
      1:       din_four = v.din;
      default: din_one  = v.din[0];
    endcase
    sb.push_back(v);
  endtask

  task automatic checkOutput();
    vec_t       e;
    logic [1:0] a_data, a_busy, a_rise, a_fall;
    string      tag;
    tag = $sformatf("%s[%0d]", phase, vec_idx);
    if (sb.size() == 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL %s scoreboard: got empty queue, expected an entry", tag);
      return;
    end
    e = sb.pop_front();
    case (sel)
      0: begin
        a_data = data_def; a_busy = busy_def; a_rise = rise_def; a_fall = fall_def;
      end
      1: begin
        a_data = data_four; a_busy = busy_four; a_rise = rise_four; a_fall = fall_four;
      end
      default: begin
        a_data = {1'b0, data_one}; a_busy = {1'b0, busy_one};
        a_rise = {1'b0, rise_one}; a_fall = {1'b0, fall_one};
      end
    endcase
    check({tag, " data"}, a_data, e.data);
    check({tag, " busy"}, a_busy, e.busy);
    check({tag, " rise"}, a_rise, e.rise);
    check({tag, " fall"}, a_fall, e.fall);
    vec_idx++;
  endtask

  task automatic run_table(input string name, input int which);
    phase   = name;
    sel     = which;
    vec_idx = 0;
    foreach (tab[k]) begin
      applyStimulus(tab[k]);
      @(posedge clk);
      @(negedge clk);
      checkOutput();
    end
    tab.delete();
  endtask

  initial begin
    // Reset values with inputs disagreeing with RST_VAL.
    #12;
    check("reset def data", data_def, 2'b10);
    check("reset def busy", busy_def, 2'b00);
    check("reset def rise", rise_def, 2'b00);
    check("reset def fall", fall_def, 2'b00);
    check("reset four data", data_four, 2'b01);
    check("reset one data", {1'b0, data_one}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // Default length: 99 settling edges, the 100th accepts the new level.
    for (int n = 0; n < 99; n++) tab.push_back(mk(2'b01, 2'b10, 2'b11, 2'b00, 2'b00));
    tab.push_back(mk(2'b01, 2'b01, 2'b00, 2'b01, 2'b10));
    tab.push_back(mk(2'b01, 2'b01, 2'b00, 2'b00, 2'b00));
    run_table("def_step", 0);

    // bit1 glitches high for 3 samples then returns low.
    tab.push_back(mk(2'b11, 2'b01, 2'b10, 2'b00, 2'b00));
    tab.push_back(mk(2'b11, 2'b01, 2'b10, 2'b00, 2'b00));
    tab.push_back(mk(2'b11, 2'b01, 2'b10, 2'b00, 2'b00));
    tab.push_back(mk(2'b01, 2'b01, 2'b00, 2'b00, 2'b00));
    tab.push_back(mk(2'b01, 2'b01, 2'b00, 2'b00, 2'b00));
    run_table("glitch", 1);

    // Pattern 1,1,1,0,1,1,1,1 on bit1: rises on the 8th edge.
    tab.push_back(mk(2'b11, 2'b01, 2'b10, 2'b00, 2'b00));
    tab.push_back(mk(2'b11, 2'b01, 2'b10, 2'b00, 2'b00));
    tab.push_back(mk(2'b11, 2'b01, 2'b10, 2'b00, 2'b00));
    tab.push_back(mk(2'b01, 2'b01, 2'b00, 2'b00, 2'b00));
    tab.push_back(mk(2'b11, 2'b01, 2'b10, 2'b00, 2'b00));
    tab.push_back(mk(2'b11, 2'b01, 2'b10, 2'b00, 2'b00));
    tab.push_back(mk(2'b11, 2'b01, 2'b10, 2'b00, 2'b00));
    tab.push_back(mk(2'b11, 2'b11, 2'b00, 2'b10, 2'b00));
    tab.push_back(mk(2'b11, 2'b11, 2'b00, 2'b00, 2'b00));
    run_table("restart", 1);

    // bit0 falls while bit1 glitches low in the same cycles.
    tab.push_back(mk(2'b00, 2'b11, 2'b11, 2'b00, 2'b00));
    tab.push_back(mk(2'b00, 2'b11, 2'b11, 2'b00, 2'b00));
    tab.push_back(mk(2'b10, 2'b11, 2'b01, 2'b00, 2'b00));
    tab.push_back(mk(2'b10, 2'b10, 2'b00, 2'b00, 2'b01));
    tab.push_back(mk(2'b10, 2'b10, 2'b00, 2'b00, 2'b00));
    run_table("indep", 1);

    // Two settling samples on bit0, then reset lands mid-count.
    tab.push_back(mk(2'b11, 2'b10, 2'b01, 2'b00, 2'b00));
    tab.push_back(mk(2'b11, 2'b10, 2'b01, 2'b00, 2'b00));
    run_table("pre_reset", 1);
    rst_n = 1'b0;
    #1;
    check("midreset data", data_four, 2'b01);
    check("midreset busy", busy_four, 2'b00);
    check("midreset rise", rise_four, 2'b00);
    check("midreset fall", fall_four, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    // bit1 must settle a full 4 samples against its reset value of 0.
    tab.push_back(mk(2'b11, 2'b01, 2'b10, 2'b00, 2'b00));
    tab.push_back(mk(2'b11, 2'b01, 2'b10, 2'b00, 2'b00));
    tab.push_back(mk(2'b11, 2'b01, 2'b10, 2'b00, 2'b00));
    tab.push_back(mk(2'b11, 2'b11, 2'b00, 2'b10, 2'b00));
    tab.push_back(mk(2'b11, 2'b11, 2'b00, 2'b00, 2'b00));
    run_table("post_reset", 1);

    // DEBOUNCE_CNT=1: output follows input one cycle later, never busy.
    tab.push_back(mk(2'b01, 2'b01, 2'b00, 2'b01, 2'b00));
    tab.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b01));
    tab.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    tab.push_back(mk(2'b01, 2'b01, 2'b00, 2'b01, 2'b00));
    tab.push_back(mk(2'b01, 2'b01, 2'b00, 2'b00, 2'b00));
    tab.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b01));
    run_table("cnt_one", 2);

    check("scoreboard drained", 2'(sb.size()), 2'b00);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
